flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/flag_unit.sv | 99 +++++++++
 tb/tb_flag_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// flag_unit: ALU condition flags (Z, V, N) with same-cycle bypass and a save/restore stack.
// Define FLAG_CARRY_EN to add the carry flag C at flags[3] and the alu_cout input.
module flag_unit #(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4,
    localparam int CW         = $clog2(STACK_DEPTH + 1),
`ifdef FLAG_CARRY_EN
    localparam int FW         = 4
`else
    localparam int FW         = 3
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        upd_class,
    input  logic              dis,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_ovfl,
`ifdef FLAG_CARRY_EN
    input  logic              alu_cout,
`endif
    input  logic              push,
    input  logic              pop,
    output logic [FW-1:0]     flags,
    output logic [CW-1:0]     stack_cnt,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(STACK_DEPTH);

    logic [FW-1:0] flags_q, flags_d, new_f, alu_f;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [FW-1:0] stack_q [STACK_DEPTH];
    logic          en_z, en_nv;
    logic          push_ok, pop_ok;
    logic [IW-1:0] wr_idx, rd_idx;

    assign en_z   = !dis && (upd_class == 2'b01 || upd_class == 2'b10);
    assign en_nv  = !dis && (upd_class == 2'b10);
    assign wr_idx = IW'(cnt_q);
    assign rd_idx = IW'(cnt_q - CW'(1));

    assign push_ok = !dis && push && !pop && (cnt_q != DEPTH_C);
    assign pop_ok  = !dis && pop && !push && (cnt_q != '0);

    always_comb begin
        new_f    = '0;
        new_f[0] = (alu_out == '0);
        new_f[1] = alu_ovfl;
        new_f[2] = alu_out[DATA_W-1];
`ifdef FLAG_CARRY_EN
        new_f[3] = alu_cout;
`endif
        alu_f = flags_q;
        if (en_z) alu_f[0] = new_f[0];
        if (en_nv) alu_f[FW-1:1] = new_f[FW-1:1];
    end

    // The visible flags are exactly what the registers load next edge, so one path feeds both.
    assign flags_d = pop_ok ? stack_q[rd_idx] : alu_f;
    assign flags   = flags_d;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok) cnt_d = cnt_q + CW'(1);
        else if (pop_ok) cnt_d = cnt_q - CW'(1);
        err_d = err_q;
        if (!dis && push && pop) err_d = 1'b1;
        if (!dis && push && !pop && cnt_q == DEPTH_C) err_d = 1'b1;
        if (!dis && pop && !push && cnt_q == '0) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Entry contents need no reset; cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst && push_ok) stack_q[wr_idx] <= flags_d;
    end

    assign stack_cnt   = cnt_q;
    assign stack_full  = (cnt_q == DEPTH_C);
    assign stack_empty = (cnt_q == '0);
    assign stack_err   = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// Randomized and directed bench for flag_unit against a queue-based flag/stack model.
module tb_flag_unit;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);
`ifdef FLAG_CARRY_EN
    localparam int FW = 4;
`else
    localparam int FW = 3;
`endif

    logic              clk;
    logic              rst;
    logic [1:0]        upd_class;
    logic              dis;
    logic [DATA_W-1:0] alu_out;
    logic              alu_ovfl;
    logic              alu_cout;
    logic              push;
    logic              pop;
    logic [FW-1:0]     flags;
    logic [CW-1:0]     stack_cnt;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;

    int n_checks = 0;
    int n_errors = 0;

    flag_unit #(.DATA_W(DATA_W), .STACK_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .upd_class  (upd_class),
        .dis        (dis),
        .alu_out    (alu_out),
        .alu_ovfl   (alu_ovfl),
`ifdef FLAG_CARRY_EN
        .alu_cout   (alu_cout),
`endif
        .push       (push),
        .pop        (pop),
        .flags      (flags),
        .stack_cnt  (stack_cnt),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .stack_err  (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain flag vector, a queue as the save stack, a sticky error bit.
    logic [FW-1:0] m_flags;
    logic [FW-1:0] m_stk[$];
    logic          m_err;
    bit            chk_en = 1'b0;

    function automatic logic [FW-1:0] model_flags();
        logic [FW-1:0] f;
        f = m_flags;
        if (!dis && pop && !push && m_stk.size() > 0) return m_stk[m_stk.size()-1];
        if (!dis && upd_class == 2'b10) begin
            f[2] = alu_out[DATA_W-1];
            f[1] = alu_ovfl;
            f[0] = (alu_out == 0);
`ifdef FLAG_CARRY_EN
            f[3] = alu_cout;
`endif
        end else if (!dis && upd_class == 2'b01) begin
            f[0] = (alu_out == 0);
        end
        return f;
    endfunction

    task automatic model_step();
        logic [FW-1:0] f;
        f = model_flags();
        if (!dis) begin
            if (push && pop) m_err = 1'b1;
            else if (push) begin
                if (m_stk.size() < DEPTH) m_stk.push_back(f);
                else m_err = 1'b1;
            end else if (pop) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_err = 1'b1;
            end
        end
        m_flags = f;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst) begin
            check("flags", 32'(flags), 32'(model_flags()));
            check("stack_cnt", 32'(stack_cnt), 32'(m_stk.size()));
            check("stack_full", 32'(stack_full), 32'(m_stk.size() == DEPTH));
            check("stack_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
            check("stack_err", 32'(stack_err), 32'(m_err));
        end
    end

    task automatic set_idle();
        upd_class = 2'b00;
        dis       = 1'b0;
        alu_out   = '0;
        alu_ovfl  = 1'b0;
        alu_cout  = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
    endtask

    // One clock cycle: apply inputs, capture flags mid-cycle, advance the model at the edge.
    task automatic cyc(input logic [1:0] c, input logic d, input logic [DATA_W-1:0] o,
                       input logic v, input logic pu, input logic po, output logic [FW-1:0] seen);
        upd_class = c;
        dis       = d;
        alu_out   = o;
        alu_ovfl  = v;
        alu_cout  = 1'($urandom_range(0, 1));
        push      = pu;
        pop       = po;
        @(negedge clk);
        #1 seen = flags;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input bit pin);
        chk_en = 1'b0;
        set_idle();
        #2 rst = 1'b0;
        #1;
        if (pin) begin
            check("rst_flags", 32'(flags), 32'h0);
            check("rst_cnt", 32'(stack_cnt), 32'h0);
            check("rst_err", 32'(stack_err), 32'h0);
            check("rst_empty", 32'(stack_empty), 32'h1);
            check("rst_full", 32'(stack_full), 32'h0);
        end
        @(negedge clk);
        @(negedge clk);
        m_flags = '0;
        m_stk.delete();
        m_err = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;
    endtask

    initial begin
        logic [FW-1:0]     s;
        logic [DATA_W-1:0] o;
        rst = 1'b0;
        set_idle();
        do_reset(1'b1);

        cyc(2'b10, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, s);
        check("nvz_bypass", 32'(s[2:0]), 32'b110);
        cyc(2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, s);
        check("nvz_registered", 32'(s[2:0]), 32'b110);
        cyc(2'b01, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, s);
        check("z_only", 32'(s[2:0]), 32'b111);
        cyc(2'b10, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, s);
        check("dis_bypass", 32'(s[2:0]), 32'b111);
        cyc(2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, s);
        check("dis_hold", 32'(s[2:0]), 32'b111);

        cyc(2'b10, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, s);
        cyc(2'b01, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, s);
        check("setup_101", 32'(s[2:0]), 32'b101);
        cyc(2'b00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, s);
        check("push_cnt", 32'(stack_cnt), 32'd1);
        cyc(2'b10, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, s);
        check("alu_clear", 32'(s[2:0]), 32'b000);
        cyc(2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, s);
        check("pop_bypass", 32'(s[2:0]), 32'b101);
        check("pop_cnt", 32'(stack_cnt), 32'd0);

        do_reset(1'b0);
        cyc(2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, s);
        check("underflow_err", 32'(stack_err), 32'h1);

        do_reset(1'b0);
        for (int i = 1; i <= 5; i++) begin
            cyc(2'b00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, s);
            if (i == 4) begin
                check("full_after_4", 32'(stack_full), 32'h1);
                check("err_after_4", 32'(stack_err), 32'h0);
            end
        end
        check("overflow_err", 32'(stack_err), 32'h1);
        check("overflow_cnt", 32'(stack_cnt), 32'd4);

        do_reset(1'b0);
        cyc(2'b00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, s);
        cyc(2'b00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, s);
        cyc(2'b10, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b1, s);
        check("collide_cnt", 32'(stack_cnt), 32'd2);
        check("collide_err", 32'(stack_err), 32'h1);
        check("collide_alu", 32'(s[2:0]), 32'b110);
        do_reset(1'b1);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset(1'b0);
            case ($urandom_range(0, 3))
                0:       o = '0;
                1:       o = 16'h8000;
                default: o = DATA_W'($urandom);
            endcase
            cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0), o,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 3) == 0), s);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
